// File: rtl/filter_matrix_stream.sv
// Row-serial activation/weight pair matrix: latches one frame of N activation and N weight
// division results, streams the N x N pair matrix one row per beat, then reports the drop count.
module filter_matrix_stream #(
  parameter int N  = 6,
  parameter int OW = 3,
  parameter int WW = 4,
  localparam int CW = $clog2(N*N+1),
  localparam int RW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            m,
  input  logic                  sym_en,
  input  logic [N-1:0]          div_bit_a,
  input  logic [N-1:0]          div_bit_w,
  input  logic [N*WW-1:0]       div_weight_a,
  input  logic [N*WW-1:0]       div_weight_w,
  input  logic [N*OW-1:0]       div_out_a,
  input  logic [N*OW-1:0]       div_out_w,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RW-1:0]         out_row,
  output logic                  out_last,
  output logic [N*2*OW-1:0]     filt_out,
  output logic [N*(WW+1)-1:0]   filt_weight,
  output logic [N-1:0]          filt_bit,
  output logic [N-1:0]          drop,
  output logic [CW-1:0]         drop_cnt,
  output logic                  cnt_valid
);

  localparam int CMPW = (WW + 1 > 4) ? WW + 1 : 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, stateNext;
  logic [RW-1:0]   rowIdx;
  logic [N-1:0]    bitA, bitW;
  logic [WW-1:0]   wA [N];
  logic [WW-1:0]   wW [N];
  logic [OW-1:0]   oA [N];
  logic [OW-1:0]   oW [N];
  logic [3:0]      mReg;
  logic            symReg;
  logic            accept, beatDone, lastBeat;
  logic [CW-1:0]   popCount;
  logic            pairSwap [N];
  logic            pairBit  [N];
  logic [WW:0]     pairSum  [N];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RUN);
  assign cnt_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign beatDone  = out_valid & out_ready;
  assign lastBeat  = (rowIdx == RW'(N-1));
  assign out_last  = lastBeat & out_valid;
  assign out_row   = rowIdx;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = RUN;
      RUN:     if (beatDone && lastBeat) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // The whole frame, including threshold and symmetry mode, is frozen at accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitA   <= '0;
      bitW   <= '0;
      mReg   <= '0;
      symReg <= 1'b0;
      for (int k = 0; k < N; k++) begin
        wA[k] <= '0;
        wW[k] <= '0;
        oA[k] <= '0;
        oW[k] <= '0;
      end
    end else if (accept) begin
      bitA   <= div_bit_a;
      bitW   <= div_bit_w;
      mReg   <= m;
      symReg <= sym_en;
      for (int k = 0; k < N; k++) begin
        wA[k] <= div_weight_a[k*WW +: WW];
        wW[k] <= div_weight_w[k*WW +: WW];
        oA[k] <= div_out_a[k*OW +: OW];
        oW[k] <= div_out_w[k*OW +: OW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rowIdx   <= '0;
      drop_cnt <= '0;
    end else if (accept) begin
      rowIdx   <= '0;
      drop_cnt <= '0;
    end else if (beatDone) begin
      rowIdx   <= lastBeat ? '0 : rowIdx + RW'(1);
      drop_cnt <= drop_cnt + popCount;
    end
  end

  // Below the diagonal in symmetric mode, bit/weight/drop come from the transposed pair.
  always_comb begin
    filt_out    = '0;
    filt_weight = '0;
    filt_bit    = '0;
    drop        = '0;
    popCount    = '0;
    for (int j = 0; j < N; j++) begin
      pairSwap[j] = symReg && (rowIdx > RW'(j));
      pairBit[j]  = pairSwap[j] ? (bitA[j] & bitW[rowIdx]) : (bitA[rowIdx] & bitW[j]);
      pairSum[j]  = pairSwap[j] ? ({1'b0, wA[j]} + {1'b0, wW[rowIdx]})
                                : ({1'b0, wA[rowIdx]} + {1'b0, wW[j]});
      if (out_valid) begin
        filt_out[j*2*OW +: 2*OW]      = {oA[rowIdx], oW[j]};
        filt_weight[j*(WW+1) +: WW+1] = pairSum[j];
        filt_bit[j]                   = pairBit[j];
        drop[j]                       = ~pairBit[j] | (CMPW'(pairSum[j]) < CMPW'(mReg));
        popCount                      = popCount + CW'(drop[j]);
      end
    end
  end

endmodule
